// File: rtl/io_ring_pkg.sv
// Shared types for the IO pad ring power sequencer.
// Holds the sequencer state encoding and the nominal settle count.
package io_ring_pkg;

  typedef enum logic [3:0] {
    OFF,
    UP_EN,
    UP_WAIT,
    UP_SETTLE,
    RELEASE,
    ON,
    DN_HOLD,
    DN_DIS,
    DN_SETTLE,
    FAULT
  } ring_state_e;

  localparam int unsigned DEFAULT_SETTLE = 3;

endpackage

// File: rtl/io_ring_seq_cnt.sv
// Loadable saturating up/down counter with a zero flag.
// One instance serves both the power-good timeout and the settle delays.
module io_ring_seq_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  // Both directions saturate so a long wait can never wrap into a false match
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/io_ring_pwr_seq.sv
// IO pad ring supply sequencer: ordered segment enable with power-good wait,
// settle delay, retention/OE release, ordered power-down and timeout fault.
module io_ring_pwr_seq
  import io_ring_pkg::*;
#(
  parameter int NSEG  = 4,
  parameter int CNT_W = 16,
  parameter int SEG_W = (NSEG > 1) ? $clog2(NSEG) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwr_up_req,
  input  logic             pwr_dn_req,
  input  logic [CNT_W-1:0] settle_cycles,
  input  logic [CNT_W-1:0] timeout_cycles,
  input  logic [NSEG-1:0]  seg_pgood,
  output logic [NSEG-1:0]  seg_en,
  output logic             pad_retention,
  output logic             pad_oe_rel,
  output logic             ready,
  output logic             busy,
  output logic             err,
  output logic [SEG_W-1:0] err_seg
);

  ring_state_e      state_q, state_d;
  logic [SEG_W-1:0] idx_q, idx_d;
  logic [NSEG-1:0]  seg_en_d;
  logic             ret_d, oe_d, ready_d, busy_d, err_d;
  logic [SEG_W-1:0] err_seg_d;

  logic             cnt_clr, cnt_load, cnt_inc, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt;
  logic             timeout_hit, last_seg, abort;

  function automatic logic [SEG_W-1:0] top_enabled(input logic [NSEG-1:0] en);
    logic [SEG_W-1:0] r;
    r = '0;
    for (int i = 0; i < NSEG; i++) begin
      if (en[i]) r = SEG_W'(i);
    end
    return r;
  endfunction

  io_ring_seq_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .load_val (settle_cycles),
    .inc      (cnt_inc),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  assign timeout_hit = (timeout_cycles != '0) && (cnt == timeout_cycles - CNT_W'(1));
  assign last_seg    = (idx_q == SEG_W'(NSEG - 1));
  assign abort       = pwr_dn_req && (state_q inside {UP_EN, UP_WAIT, UP_SETTLE, RELEASE, ON});

  // Every output is computed for the cycle after the transition and registered
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    seg_en_d  = seg_en;
    ret_d     = pad_retention;
    oe_d      = pad_oe_rel;
    ready_d   = ready;
    err_d     = err;
    err_seg_d = err_seg;
    cnt_clr   = 1'b0;
    cnt_load  = 1'b0;
    cnt_inc   = 1'b0;
    cnt_dec   = 1'b0;

    if (abort) begin
      state_d = DN_HOLD;
      oe_d    = 1'b0;
      ready_d = 1'b0;
    end else begin
      case (state_q)
        OFF: begin
          if (pwr_up_req && !pwr_dn_req) begin
            idx_d   = '0;
            state_d = UP_EN;
          end
        end
        UP_EN: begin
          seg_en_d[idx_q] = 1'b1;
          cnt_clr         = 1'b1;
          state_d         = UP_WAIT;
        end
        UP_WAIT: begin
          if (seg_pgood[idx_q]) begin
            cnt_load = 1'b1;
            state_d  = UP_SETTLE;
          end else if (timeout_hit) begin
            seg_en_d  = '0;
            ret_d     = 1'b1;
            oe_d      = 1'b0;
            ready_d   = 1'b0;
            err_d     = 1'b1;
            err_seg_d = idx_q;
            state_d   = FAULT;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        UP_SETTLE: begin
          if (!cnt_zero) begin
            cnt_dec = 1'b1;
          end else if (last_seg) begin
            ret_d   = 1'b0;
            state_d = RELEASE;
          end else begin
            idx_d   = idx_q + SEG_W'(1);
            state_d = UP_EN;
          end
        end
        RELEASE: begin
          oe_d    = 1'b1;
          ready_d = 1'b1;
          state_d = ON;
        end
        ON: begin
          state_d = ON;
        end
        // Retention is re-applied one cycle after OE is withdrawn
        DN_HOLD: begin
          ret_d   = 1'b1;
          idx_d   = top_enabled(seg_en);
          state_d = DN_DIS;
        end
        DN_DIS: begin
          seg_en_d[idx_q] = 1'b0;
          cnt_load        = 1'b1;
          state_d         = DN_SETTLE;
        end
        DN_SETTLE: begin
          if (!cnt_zero) begin
            cnt_dec = 1'b1;
          end else if (|seg_en) begin
            idx_d   = top_enabled(seg_en);
            state_d = DN_DIS;
          end else begin
            state_d = OFF;
          end
        end
        FAULT: begin
          state_d = FAULT;
        end
        default: begin
          state_d = OFF;
        end
      endcase
    end

    busy_d = !(state_d inside {OFF, ON, FAULT});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= OFF;
      idx_q         <= '0;
      seg_en        <= '0;
      pad_retention <= 1'b1;
      pad_oe_rel    <= 1'b0;
      ready         <= 1'b0;
      busy          <= 1'b0;
      err           <= 1'b0;
      err_seg       <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      seg_en        <= seg_en_d;
      pad_retention <= ret_d;
      pad_oe_rel    <= oe_d;
      ready         <= ready_d;
      busy          <= busy_d;
      err           <= err_d;
      err_seg       <= err_seg_d;
    end
  end

endmodule

// File: tb/tb_io_ring_pwr_seq.sv
// Bench for io_ring_pwr_seq: per-scenario expected timelines are queued as
// absolute-cycle records and compared as the DUT reaches each cycle.
module tb_io_ring_pwr_seq;
  import io_ring_pkg::*;

  localparam int NSEG  = 4;
  localparam int CNT_W = 16;
  localparam int SEG_W = 2;
  localparam int OW    = NSEG + SEG_W + 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             pwr_up_req = 1'b0;
  logic             pwr_dn_req = 1'b0;
  logic [CNT_W-1:0] settle_cycles = '0;
  logic [CNT_W-1:0] timeout_cycles = '0;
  logic [NSEG-1:0]  seg_pgood;
  logic [NSEG-1:0]  seg_en;
  logic             pad_retention, pad_oe_rel, ready, busy, err;
  logic [SEG_W-1:0] err_seg;

  logic [NSEG-1:0]  pg_stuck = '0;
  int               pg_dly = 1;
  int               en_age [NSEG];
  int               cyc = 0;
  int               checks = 0;
  int               errors = 0;
  logic [NSEG-1:0]  seen_or;

  typedef struct {
    int               off;
    logic [NSEG-1:0]  seg;
    logic             ret, oe, rdy, bsy, er;
    logic [SEG_W-1:0] es;
  } vec_t;

  typedef struct {
    int          cyc;
    string       name;
    logic [OW-1:0] v;
  } exp_t;

  vec_t tab[$];
  exp_t sb[$];

  io_ring_pwr_seq #(.NSEG(NSEG), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .pwr_up_req     (pwr_up_req),
    .pwr_dn_req     (pwr_dn_req),
    .settle_cycles  (settle_cycles),
    .timeout_cycles (timeout_cycles),
    .seg_pgood      (seg_pgood),
    .seg_en         (seg_en),
    .pad_retention  (pad_retention),
    .pad_oe_rel     (pad_oe_rel),
    .ready          (ready),
    .busy           (busy),
    .err            (err),
    .err_seg        (err_seg)
  );

  always #5 clk = ~clk;

  // Supply model: power-good follows an enable after pg_dly cycles unless stuck low
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < NSEG; i++) en_age[i] <= seg_en[i] ? en_age[i] + 1 : 0;
  end

  always_comb begin
    seg_pgood = '0;
    for (int i = 0; i < NSEG; i++)
      seg_pgood[i] = seg_en[i] && !pg_stuck[i] && (en_age[i] >= pg_dly);
  end

  function automatic logic [OW-1:0] pack(input logic [NSEG-1:0] s, input logic r, input logic o,
                                         input logic y, input logic b, input logic e,
                                         input logic [SEG_W-1:0] es);
    return {s, r, o, y, b, e, es};
  endfunction

  function automatic logic [OW-1:0] obs();
    return pack(seg_en, pad_retention, pad_oe_rel, ready, busy, err, err_seg);
  endfunction

  task automatic check(input string name, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b want=%b (seg_en,ret,oe,ready,busy,err,err_seg)", name, got, exp);
    end
  endtask

  task automatic row(input int off, input logic [NSEG-1:0] s, input logic r, input logic o,
                     input logic y, input logic b, input logic e, input logic [SEG_W-1:0] es);
    vec_t v;
    v.off = off; v.seg = s; v.ret = r; v.oe = o; v.rdy = y; v.bsy = b; v.er = e; v.es = es;
    tab.push_back(v);
  endtask

  task automatic issue(input string scen, input int t0);
    foreach (tab[i]) begin
      exp_t e;
      e.cyc  = t0 + tab[i].off;
      e.name = $sformatf("%s@+%0d", scen, tab[i].off);
      e.v    = pack(tab[i].seg, tab[i].ret, tab[i].oe, tab[i].rdy, tab[i].bsy, tab[i].er, tab[i].es);
      sb.push_back(e);
    end
    tab.delete();
  endtask

  task automatic step();
    @(negedge clk);
    seen_or = seen_or | seg_en;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      check(e.name, obs(), e.v);
    end
    #1;
  endtask

  task automatic goto(input int t);
    while (cyc < t) step();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() > 0 && n < budget) begin
      step();
      n++;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending=%0d want=0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d want=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int n;
    seen_or = '0;
    settle_cycles  = CNT_W'(DEFAULT_SETTLE);
    timeout_cycles = '0;
    step(); step();

    // Reset values while rst is held
    t0 = cyc;
    row(1, 4'b0000, 1, 0, 0, 0, 0, 2'd0);
    issue("reset", t0);
    drain(5);
    rst = 1'b0;
    step();

    // Both requests in OFF: stay in OFF
    t0 = cyc;
    pwr_up_req = 1'b1; pwr_dn_req = 1'b1;
    row(1, 4'b0000, 1, 0, 0, 0, 0, 2'd0);
    row(2, 4'b0000, 1, 0, 0, 0, 0, 2'd0);
    row(4, 4'b0000, 1, 0, 0, 0, 0, 2'd0);
    issue("both_req", t0);
    goto(t0 + 4);
    pwr_up_req = 1'b0; pwr_dn_req = 1'b0;
    drain(5);

    // Power-up, settle 3, power-good one cycle after enable: 7-cycle spacing
    timeout_cycles = 16'd50;
    t0 = cyc;
    pwr_up_req = 1'b1;
    row(1,  4'b0000, 1, 0, 0, 1, 0, 2'd0);
    row(2,  4'b0001, 1, 0, 0, 1, 0, 2'd0);
    row(8,  4'b0001, 1, 0, 0, 1, 0, 2'd0);
    row(9,  4'b0011, 1, 0, 0, 1, 0, 2'd0);
    row(15, 4'b0011, 1, 0, 0, 1, 0, 2'd0);
    row(16, 4'b0111, 1, 0, 0, 1, 0, 2'd0);
    row(22, 4'b0111, 1, 0, 0, 1, 0, 2'd0);
    row(23, 4'b1111, 1, 0, 0, 1, 0, 2'd0);
    row(28, 4'b1111, 1, 0, 0, 1, 0, 2'd0);
    row(29, 4'b1111, 0, 0, 0, 1, 0, 2'd0);
    row(30, 4'b1111, 0, 1, 1, 0, 0, 2'd0);
    row(34, 4'b1111, 0, 1, 1, 0, 0, 2'd0);
    issue("up", t0);
    step();
    pwr_up_req = 1'b0;
    goto(t0 + 31);
    pg_stuck = 4'b1111;
    goto(t0 + 35);
    pg_stuck = '0;
    drain(20);

    // Power-down from ON: top segment first, 5-cycle spacing
    t0 = cyc;
    pwr_dn_req = 1'b1;
    row(1,  4'b1111, 0, 0, 0, 1, 0, 2'd0);
    row(2,  4'b1111, 1, 0, 0, 1, 0, 2'd0);
    row(3,  4'b0111, 1, 0, 0, 1, 0, 2'd0);
    row(7,  4'b0111, 1, 0, 0, 1, 0, 2'd0);
    row(8,  4'b0011, 1, 0, 0, 1, 0, 2'd0);
    row(12, 4'b0011, 1, 0, 0, 1, 0, 2'd0);
    row(13, 4'b0001, 1, 0, 0, 1, 0, 2'd0);
    row(17, 4'b0001, 1, 0, 0, 1, 0, 2'd0);
    row(18, 4'b0000, 1, 0, 0, 1, 0, 2'd0);
    row(21, 4'b0000, 1, 0, 0, 1, 0, 2'd0);
    row(22, 4'b0000, 1, 0, 0, 0, 0, 2'd0);
    issue("down", t0);
    drain(40);
    pwr_dn_req = 1'b0;
    step();

    // Abort during segment 1 settle
    seen_or = '0;
    t0 = cyc;
    pwr_up_req = 1'b1;
    row(12, 4'b0011, 1, 0, 0, 1, 0, 2'd0);
    row(13, 4'b0011, 1, 0, 0, 1, 0, 2'd0);
    row(15, 4'b0001, 1, 0, 0, 1, 0, 2'd0);
    row(19, 4'b0001, 1, 0, 0, 1, 0, 2'd0);
    row(20, 4'b0000, 1, 0, 0, 1, 0, 2'd0);
    row(23, 4'b0000, 1, 0, 0, 1, 0, 2'd0);
    row(24, 4'b0000, 1, 0, 0, 0, 0, 2'd0);
    issue("abort", t0);
    step();
    pwr_up_req = 1'b0;
    goto(t0 + 12);
    pwr_dn_req = 1'b1;
    goto(t0 + 25);
    pwr_dn_req = 1'b0;
    drain(5);
    check("abort_seen_seg_en", {{(OW-NSEG){1'b0}}, seen_or}, {{(OW-NSEG){1'b0}}, 4'b0011});

    // Reset during segment 3 power-good wait
    t0 = cyc;
    pwr_up_req = 1'b1;
    row(23, 4'b1111, 1, 0, 0, 1, 0, 2'd0);
    row(24, 4'b0000, 1, 0, 0, 0, 0, 2'd0);
    row(27, 4'b0000, 1, 0, 0, 0, 0, 2'd0);
    issue("mid_rst", t0);
    step();
    pwr_up_req = 1'b0;
    goto(t0 + 23);
    rst = 1'b1;
    step();
    rst = 1'b0;
    drain(10);

    // Segment 2 power-good stuck low, timeout 10
    pg_stuck = 4'b0100;
    timeout_cycles = 16'd10;
    t0 = cyc;
    pwr_up_req = 1'b1;
    row(16, 4'b0111, 1, 0, 0, 1, 0, 2'd0);
    row(25, 4'b0111, 1, 0, 0, 1, 0, 2'd0);
    row(26, 4'b0000, 1, 0, 0, 0, 1, 2'd2);
    row(32, 4'b0000, 1, 0, 0, 0, 1, 2'd2);
    row(34, 4'b0000, 1, 0, 0, 0, 0, 2'd0);
    issue("fault", t0);
    step();
    pwr_up_req = 1'b0;
    goto(t0 + 28);
    pwr_up_req = 1'b1;
    step();
    pwr_up_req = 1'b0;
    goto(t0 + 30);
    pwr_dn_req = 1'b1;
    step();
    pwr_dn_req = 1'b0;
    goto(t0 + 33);
    rst = 1'b1;
    step();
    rst = 1'b0;
    drain(10);
    pg_stuck = '0;
    timeout_cycles = '0;

    // Zero settle, no timeout, immediate power-good: 3 cycles per segment
    settle_cycles = '0;
    pg_dly = 0;
    t0 = cyc;
    pwr_up_req = 1'b1;
    row(2,  4'b0001, 1, 0, 0, 1, 0, 2'd0);
    row(4,  4'b0001, 1, 0, 0, 1, 0, 2'd0);
    row(5,  4'b0011, 1, 0, 0, 1, 0, 2'd0);
    row(8,  4'b0111, 1, 0, 0, 1, 0, 2'd0);
    row(11, 4'b1111, 1, 0, 0, 1, 0, 2'd0);
    row(12, 4'b1111, 1, 0, 0, 1, 0, 2'd0);
    row(13, 4'b1111, 0, 0, 0, 1, 0, 2'd0);
    row(14, 4'b1111, 0, 1, 1, 0, 0, 2'd0);
    issue("fast_up", t0);
    step();
    pwr_up_req = 1'b0;
    drain(30);
    t0 = cyc;
    pwr_dn_req = 1'b1;
    row(3,  4'b0111, 1, 0, 0, 1, 0, 2'd0);
    row(5,  4'b0011, 1, 0, 0, 1, 0, 2'd0);
    row(7,  4'b0001, 1, 0, 0, 1, 0, 2'd0);
    row(9,  4'b0000, 1, 0, 0, 1, 0, 2'd0);
    row(10, 4'b0000, 1, 0, 0, 0, 0, 2'd0);
    issue("fast_dn", t0);
    drain(30);
    pwr_dn_req = 1'b0;
    step();

    // 2000-cycle power-good delay with timeout disabled: no fault
    pg_dly = 2000;
    t0 = cyc;
    pwr_up_req = 1'b1;
    row(2001, 4'b0001, 1, 0, 0, 1, 0, 2'd0);
    row(2002, 4'b0001, 1, 0, 0, 1, 0, 2'd0);
    row(2005, 4'b0011, 1, 0, 0, 1, 0, 2'd0);
    issue("long_pg", t0);
    step();
    pwr_up_req = 1'b0;
    drain(2100);
    n = 0;
    while (!ready && n < 7000) begin
      step();
      n++;
    end
    check("long_pg_on", obs(), pack(4'b1111, 0, 1, 1, 0, 0, 2'd0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
